// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the execute stage and muldiv_unit
interface muldiv_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] s;
    logic [N-1:0] t;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, s, t, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, s, t, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiply / restoring divide with HI/LO registers
module muldiv_unit #(
    parameter int N = 32
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    // Multiply: {upper partial sum, remaining multiplier bits}.
    // Divide:   {remainder, dividend bits being shifted out / quotient shifted in}.
    logic [2*N-1:0]  acc_q, acc_d;
    // Multiplicand (multiply) or divisor (divide), magnitude form.
    logic [N-1:0]    opnd_q, opnd_d;
    logic [N-1:0]    orig_s_q, orig_s_d;
    logic            is_div_q, is_div_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dz_q, dz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            div_zero_q, div_zero_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;

    logic            signed_op;
    logic [N-1:0]    abs_s, abs_t;
    logic [N:0]      mul_sum;
    logic [2*N-1:0]  mul_next;
    logic [N:0]      div_sh;
    logic [N:0]      div_diff;
    logic [N-1:0]    rem_next;
    logic [2*N-1:0]  div_next;
    logic [2*N-1:0]  prod_fix;
    logic [N-1:0]    quot_fix;
    logic [N-1:0]    rem_fix;

    // Operand magnitudes and one iteration of each datapath
    always_comb begin
        signed_op = (bus.op == 3'd0) || (bus.op == 3'd2);
        abs_s     = (signed_op && bus.s[N-1]) ? -bus.s : bus.s;
        abs_t     = (signed_op && bus.t[N-1]) ? -bus.t : bus.t;

        // Add multiplicand into the upper half when the multiplier LSB is set,
        // then shift the whole product right, carry entering at the top.
        mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[N-1:1]};

        // Shift {rem, quot} left and trial-subtract; N+1 bits so the shifted
        // remainder never overflows before the compare.
        div_sh    = {acc_q[2*N-1:N], acc_q[N-1]};
        div_diff  = div_sh - {1'b0, opnd_q};
        rem_next  = div_diff[N] ? div_sh[N-1:0] : div_diff[N-1:0];
        div_next  = {rem_next, acc_q[N-2:0], ~div_diff[N]};

        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quot_fix  = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
        rem_fix   = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
    end

    // Next-state and registered-output computation for the IDLE/RUN/FIN sequence
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        orig_s_d   = orig_s_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            is_div_d  = bus.op[1];
                            acc_d     = {{N{1'b0}}, (bus.op[1] ? abs_s : abs_t)};
                            opnd_d    = bus.op[1] ? abs_t : abs_s;
                            neg_res_d = signed_op && (bus.s[N-1] ^ bus.t[N-1]);
                            neg_rem_d = signed_op && bus.s[N-1];
                            dz_d      = bus.op[1] && (bus.t == '0);
                            orig_s_d  = bus.s;
                            count_d   = '0;
                            busy_d    = 1'b1;
                            state_d   = S_RUN;
                        end
                        3'd4:    hi_d = bus.s;
                        3'd5:    lo_d = bus.s;
                        // Reserved encodings are deliberately a no-op.
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    acc_d   = is_div_q ? div_next : mul_next;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(N - 1)) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                // A squash arriving in the final cycle still discards the result.
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*N-1:N];
                        lo_d = prod_fix[N-1:0];
                    end else if (dz_q) begin
                        div_zero_d = 1'b1;
                        hi_d       = orig_s_q;
                        lo_d       = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            orig_s_q   <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            orig_s_q   <= orig_s_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
    localparam int N = 32;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    muldiv_unit_if #(.N(N)) bus ();

    muldiv_unit #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference results from plain wide arithmetic
    task automatic model(input logic [2:0] op, input logic [31:0] s, input logic [31:0] t,
                         output logic [31:0] eh, output logic [31:0] el, output logic edz);
        longint      sa, ta, p, q, r;
        logic [63:0] up;
        edz = 1'b0;
        eh  = '0;
        el  = '0;
        sa  = longint'($signed(s));
        ta  = longint'($signed(t));
        case (op)
            3'd0: begin p = sa * ta; {eh, el} = p; end
            3'd1: begin up = {32'b0, s} * {32'b0, t}; {eh, el} = up; end
            default: begin
                if (t == 0) begin
                    edz = 1'b1;
                    el  = 32'hFFFF_FFFF;
                    eh  = s;
                end else if (op == 3'd3) begin
                    el = s / t;
                    eh = s % t;
                end else begin
                    q  = sa / ta;
                    r  = sa % ta;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
        endcase
    endtask

    // Issue one MULT/DIV, time it, and compare against the model
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] s, input logic [31:0] t);
        logic [31:0] eh, el;
        logic        edz;
        int          cycles, busy_cnt;
        model(op, s, t, eh, el, edz);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.s = s; bus.t = t;
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 0; busy_cnt = 0;
        while (!bus.done && cycles < 100) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        chk({tag, ".latency"}, 64'(cycles), 64'(N + 1));
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(N + 1));
        chk({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, ".hi"}, 64'(bus.hi), 64'(eh));
        chk({tag, ".lo"}, 64'(bus.lo), 64'(el));
        chk({tag, ".div_zero"}, 64'(bus.div_zero), 64'(edz));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [31:0] hi_keep, lo_keep, rs, rt;
        logic [2:0]  rop;
        int          done_seen;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.s = '0; bus.t = '0; bus.flush = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.done", 64'(bus.done), 64'd0);
        chk("rst.div_zero", 64'(bus.div_zero), 64'd0);
        chk("rst.hi", 64'(bus.hi), 64'd0);
        chk("rst.lo", 64'(bus.lo), 64'd0);
        reset = 1'b1;

        // Directed arithmetic
        do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
        do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        do_op("divu_zero", 3'd3, 32'd100, 32'd0);
        do_op("div_zero_signed", 3'd2, 32'hFFFF_FF00, 32'd0);
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

        // MTHI then MTLO back to back
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.s = 32'h1234_5678;
        @(negedge clk);
        chk("mthi.hi", 64'(bus.hi), 64'h1234_5678);
        chk("mthi.busy", 64'(bus.busy), 64'd0);
        bus.op = 3'd5; bus.s = 32'hCAFE_BABE;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo.lo", 64'(bus.lo), 64'hCAFE_BABE);
        chk("mtlo.hi", 64'(bus.hi), 64'h1234_5678);
        chk("mtlo.busy", 64'(bus.busy), 64'd0);
        chk("mtlo.done", 64'(bus.done), 64'd0);

        // Flush in IDLE suppresses a same-cycle MTHI
        bus.start = 1'b1; bus.op = 3'd4; bus.s = 32'hDEAD_0000; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_idle.hi", 64'(bus.hi), 64'h1234_5678);

        // Flush mid-RUN at iteration 10
        hi_keep = bus.hi; lo_keep = bus.lo;
        bus.start = 1'b1; bus.op = 3'd0; bus.s = 32'd12345; bus.t = 32'hFFFF_0001;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_run.busy", 64'(bus.busy), 64'd0);
        chk("flush_run.done", 64'(bus.done), 64'd0);
        chk("flush_run.hi", 64'(bus.hi), 64'(hi_keep));
        chk("flush_run.lo", 64'(bus.lo), 64'(lo_keep));
        do_op("divu_after_flush", 3'd3, 32'd1000003, 32'd97);

        // Flush arriving in the FIN cycle discards the result
        hi_keep = bus.hi; lo_keep = bus.lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.s = 32'd77; bus.t = 32'd88;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (N) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        done_seen = 0;
        repeat (3) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        chk("flush_fin.done", 64'(done_seen), 64'd0);
        chk("flush_fin.busy", 64'(bus.busy), 64'd0);
        chk("flush_fin.hi", 64'(bus.hi), 64'(hi_keep));
        chk("flush_fin.lo", 64'(bus.lo), 64'(lo_keep));

        // Randomized operations against the model
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            rs  = $urandom;
            rt  = $urandom;
            if ($urandom_range(0, 7) == 0) rt = 32'd0;
            else if ($urandom_range(0, 2) == 0) rt = ($urandom_range(0, 1) == 1) ? -32'($urandom_range(1, 9)) : 32'($urandom_range(1, 9));
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, rs, rt);
        end

        // Asynchronous reset mid-RUN, between edges
        do_op("pre_reset", 3'd1, 32'h0001_0001, 32'h0003_0003);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.s = 32'd5; bus.t = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst.busy", 64'(bus.busy), 64'd0);
        chk("async_rst.hi", 64'(bus.hi), 64'd0);
        chk("async_rst.lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reserved op produces no response
        bus.start = 1'b1; bus.op = 3'd7; bus.s = 32'h5555_AAAA; bus.t = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        done_seen = 0;
        repeat (N + 4) begin
            if (bus.done || bus.busy) done_seen++;
            @(negedge clk);
        end
        chk("op7.activity", 64'(done_seen), 64'd0);
        chk("op7.hi", 64'(bus.hi), 64'd0);
        chk("op7.lo", 64'(bus.lo), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
